// File: rtl/healthcare_pkg.sv
// Shared types and constants for the health alert transmitter.
package healthcare_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } txState_e;

  localparam int NUM_FLAGS     = 4;
  localparam int FLAG_PRESSURE = 0;
  localparam int FLAG_BLOOD    = 1;
  localparam int FLAG_FALL     = 2;
  localparam int FLAG_TEMP     = 3;

  // start + 8 data + stop
  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/alert_serial_shifter.sv
// 8N1 serial shifter, LSB first: baud down-counter, bit counter and shift register.
//   state | meaning
//   IDLE  | line high, waiting for load
//   START | start bit (low) for CLKS_PER_BIT cycles
//   DATA  | eight data bits, LSB first
//   STOP  | stop bit (high); done pulses on its last cycle
module alert_serial_shifter
  import healthcare_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] dataByte,
  output logic       txSerial,
  output logic       busy,
  output logic       done
);

  localparam int BaudW = $clog2(CLKS_PER_BIT);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LastBit = 3'(FRAME_BITS - 3);

  txState_e state, stateNext;
  logic [BaudW-1:0] baudCnt;
  logic [2:0] bitCnt;
  logic [7:0] shiftReg;
  logic lineNext, doneNext, baudTc;

  assign baudTc = (baudCnt == '0);
  assign busy   = (state != IDLE);

  always_comb begin
    stateNext = state;
    lineNext  = txSerial;
    doneNext  = 1'b0;
    case (state)
      IDLE: begin
        lineNext = 1'b1;
        if (load) begin
          stateNext = START;
          lineNext  = 1'b0;
        end
      end
      START: begin
        if (baudTc) begin
          stateNext = DATA;
          lineNext  = shiftReg[0];
        end
      end
      DATA: begin
        if (baudTc) begin
          if (bitCnt == LastBit) begin
            stateNext = STOP;
            lineNext  = 1'b1;
          end else begin
            // shiftReg is shifted on this same edge, so bit 1 is the next data bit
            lineNext = shiftReg[1];
          end
        end
      end
      STOP: begin
        lineNext = 1'b1;
        doneNext = (baudCnt == BaudW'(1));
        if (baudTc) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baudCnt  <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
      txSerial <= 1'b1;
      done     <= 1'b0;
    end else begin
      state    <= stateNext;
      txSerial <= lineNext;
      done     <= doneNext;
      if (state == IDLE) begin
        if (load) begin
          shiftReg <= dataByte;
          baudCnt  <= BaudLast;
          bitCnt   <= '0;
        end
      end else if (baudTc) begin
        baudCnt <= BaudLast;
        if (state == DATA) begin
          bitCnt   <= bitCnt + 3'd1;
          shiftReg <= shiftReg >> 1;
        end
      end else begin
        baudCnt <= baudCnt - BaudW'(1);
      end
    end
  end

endmodule

// File: rtl/health_alert_transmitter.sv
// Samples the four detector flags, sends a frame on change or heartbeat,
// and keeps host-acknowledged sticky alarm latches.
module health_alert_transmitter
  import healthcare_pkg::*;
#(
  parameter int CLKS_PER_BIT     = 16,
  parameter int HEARTBEAT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 presureAbnormality,
  input  logic                 bloodAbnormality,
  input  logic                 fallDetected,
  input  logic                 temperatureAbnormality,
  input  logic                 ackAlarm,
  output logic                 txSerial,
  output logic                 txBusy,
  output logic                 frameSent,
  output logic [NUM_FLAGS-1:0] alarmLatched
);

  localparam int HbW = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;
  localparam logic [HbW-1:0] HbMax = HbW'((HEARTBEAT_CYCLES > 0) ? HEARTBEAT_CYCLES - 1 : 0);

  logic [NUM_FLAGS-1:0] flagsIn, flagsQ, lastSent;
  logic [3:0] seq;
  logic [HbW-1:0] hbCnt;
  logic hbHit, changed, startFrame, shifterBusy, shifterDone;

  assign flagsIn[FLAG_PRESSURE] = presureAbnormality;
  assign flagsIn[FLAG_BLOOD]    = bloodAbnormality;
  assign flagsIn[FLAG_FALL]     = fallDetected;
  assign flagsIn[FLAG_TEMP]     = temperatureAbnormality;

  assign hbHit      = (HEARTBEAT_CYCLES != 0) && (hbCnt == HbMax);
  assign changed    = (flagsQ != lastSent);
  assign startFrame = !shifterBusy && (changed || hbHit);

  always_ff @(posedge clk) begin
    if (rst) begin
      flagsQ       <= '0;
      lastSent     <= '0;
      seq          <= '0;
      hbCnt        <= '0;
      alarmLatched <= '0;
    end else begin
      flagsQ <= flagsIn;
      if (startFrame) begin
        lastSent <= flagsQ;
        hbCnt    <= '0;
      end else if (hbCnt != HbMax) begin
        hbCnt <= hbCnt + HbW'(1);
      end
      if (shifterDone) seq <= seq + 4'd1;
      // a set flag always wins; ack only clears bits whose flag is now low
      alarmLatched <= flagsQ | (alarmLatched & ~({NUM_FLAGS{ackAlarm}} & ~flagsQ));
    end
  end

  alert_serial_shifter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uShifter (
    .clk      (clk),
    .rst      (rst),
    .load     (startFrame),
    .dataByte ({seq, flagsQ}),
    .txSerial (txSerial),
    .busy     (shifterBusy),
    .done     (shifterDone)
  );

  assign txBusy    = shifterBusy;
  assign frameSent = shifterDone;

endmodule

// File: tb/tb_health_alert_transmitter.sv
// Directed + randomized bench for health_alert_transmitter with a frame-level reference model.
module tb_health_alert_transmitter;

  localparam int CPB = 4;
  localparam int HB  = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] flags = 4'b0;
  logic ack = 1'b0;
  logic txSerial, txBusy, frameSent;
  logic [3:0] alarmLatched;

  int total = 0;
  int bad = 0;
  int seqModel = 0;
  logic [3:0] flagsQm = 4'b0;
  logic [3:0] alarmM = 4'b0;

  health_alert_transmitter #(
    .CLKS_PER_BIT(CPB),
    .HEARTBEAT_CYCLES(HB)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .presureAbnormality     (flags[0]),
    .bloodAbnormality       (flags[1]),
    .fallDetected           (flags[2]),
    .temperatureAbnormality (flags[3]),
    .ackAlarm               (ack),
    .txSerial               (txSerial),
    .txBusy                 (txBusy),
    .frameSent              (frameSent),
    .alarmLatched           (alarmLatched)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  // one clock; the alarm model follows the sticky/ack rules on the sampled flags
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      alarmM  = 4'b0;
      flagsQm = 4'b0;
    end else begin
      alarmM  = flagsQm | (alarmM & ~({4{ack}} & ~flagsQm));
      flagsQm = flags;
    end
    #1;
  endtask

  // Entered on the first START cycle (k=0); returns on the first idle cycle (k=10*CPB).
  task automatic runFrame(input logic [7:0] b, input int mode);
    logic [9:0] bits;
    logic expLine;
    bits = {1'b1, b, 1'b0};
    for (int k = 0; k <= 10 * CPB; k++) begin
      if (k > 0) tick();
      expLine = (k < 10 * CPB) ? bits[k / CPB] : 1'b1;
      check("line", k, {31'b0, txSerial}, {31'b0, expLine});
      check("busy", k, {31'b0, txBusy}, {31'b0, (k < 10 * CPB)});
      check("frameSent", k, {31'b0, frameSent}, {31'b0, (k == 10 * CPB - 1)});
      if (mode == 1) begin
        if (k == 5)  flags[0] = 1'b1;
        if (k == 9)  flags[0] = 1'b0;
        if (k == 12) flags[3] = 1'b1;
      end
    end
    seqModel = (seqModel + 1) % 16;
  endtask

  // flags were just changed: line stays high one edge, goes low on the second
  task automatic expectStart(input string tag);
    tick();
    check({tag, "_preStart"}, 0, {31'b0, txSerial}, 32'd1);
    tick();
    check({tag, "_start"}, 0, {31'b0, txSerial}, 32'd0);
  endtask

  initial begin
    int sawLow;

    // 1: reset state and heartbeat
    rst = 1'b1;
    repeat (3) tick();
    check("rst_txSerial", 0, {31'b0, txSerial}, 32'd1);
    check("rst_txBusy", 0, {31'b0, txBusy}, 32'd0);
    check("rst_frameSent", 0, {31'b0, frameSent}, 32'd0);
    check("rst_alarm", 0, {28'b0, alarmLatched}, 32'd0);
    rst = 1'b0;
    seqModel = 0;
    sawLow = 0;
    for (int i = 1; i < HB; i++) begin
      tick();
      if (txSerial !== 1'b1) sawLow++;
    end
    check("hb_quiet", HB - 1, sawLow, 0);
    tick();
    check("hb_start", HB, {31'b0, txSerial}, 32'd0);
    runFrame({seqModel[3:0], flags}, 0);

    // 2/3: fall frame from fresh reset, then glitch + temperature during it
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seqModel = 0;
    flags = 4'b0100;
    expectStart("fall");
    check("alarm_fall", 0, {28'b0, alarmLatched}, {28'b0, alarmM});
    runFrame({seqModel[3:0], flags}, 1);
    tick();
    check("b2b_start", 0, {31'b0, txSerial}, 32'd0);
    runFrame({seqModel[3:0], flags}, 0);
    sawLow = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (txSerial !== 1'b1) sawLow++;
    end
    check("no_extra_frame", 0, sawLow, 0);
    check("alarm_sticky", 0, {28'b0, alarmLatched}, {28'b0, alarmM});

    // 4: ack while flags high keeps those bits, after flags drop clears them
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    check("ack_flags_high", 0, {28'b0, alarmLatched}, {28'b0, alarmM});
    flags = 4'b0000;
    expectStart("clear");
    runFrame({seqModel[3:0], flags}, 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    check("ack_flags_low", 0, {28'b0, alarmLatched}, {28'b0, alarmM});

    // 5: reset in data bit 3 aborts the frame
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seqModel = 0;
    flags = 4'b0100;
    expectStart("abort");
    for (int k = 1; k <= 4 * CPB + 1; k++) tick();
    rst = 1'b1;
    tick();
    check("abort_txSerial", 0, {31'b0, txSerial}, 32'd1);
    check("abort_txBusy", 0, {31'b0, txBusy}, 32'd0);
    check("abort_frameSent", 0, {31'b0, frameSent}, 32'd0);
    rst = 1'b0;
    seqModel = 0;
    expectStart("after_abort");
    runFrame({seqModel[3:0], flags}, 0);

    // 6: 17 random flag changes, sequence number wraps
    rst = 1'b1;
    flags = 4'b0000;
    tick();
    rst = 1'b0;
    seqModel = 0;
    for (int n = 0; n < 17; n++) begin
      flags = flags ^ 4'($urandom_range(1, 15));
      expectStart("rand");
      runFrame({seqModel[3:0], flags}, 0);
    end
    check("alarm_final", 0, {28'b0, alarmLatched}, {28'b0, alarmM});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
